pipe_mem_arb: RTL and testbench

PIPE_MEM_ARB -- requirements
Module: pipe_mem_arb

---
 rtl/pipe_mem_arb.sv | 150 +++++++++++++++
 tb/tb_pipe_mem_arb.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : pipe_mem_arb
// Brief  : Fetch/data arbiter onto a single-port memory, with fairness and watchdog.
// Rev    : 1.0
// ============================================================================
module pipe_mem_arb #(
    parameter int FAIR    = 2,
    parameter int MAXWAIT = 15
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_d,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] c_fair      = 4'(FAIR);
    localparam logic [7:0] c_wait_last = 8'(MAXWAIT - 1);

    state_t      state_q;
    logic [3:0]  streak_q;
    logic [3:0]  streak_d;
    logic [7:0]  wd_q;
    logic        mem_req_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_ready_q;
    logic        d_ready_q;
    logic        bus_err_q;
    logic        w_d_wins;
    logic        w_done;

    // Streak only grows while a fetch is actually being held off.
    always_comb begin
        streak_d = 4'd0;
        if (if_req) begin
            streak_d = (streak_q >= c_fair) ? c_fair : streak_q + 4'd1;
        end
    end

    assign w_d_wins = d_req && (!if_req || (streak_q < c_fair));
    assign w_done   = mem_ack || (wd_q == c_wait_last);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            streak_q    <= 4'd0;
            wd_q        <= 8'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
            if_ready_q  <= 1'b0;
            d_ready_q   <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_d_wins) begin
                        state_q     <= BUS_D;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= d_we;
                        mem_addr_q  <= d_addr;
                        mem_wdata_q <= d_wdata;
                        streak_q    <= streak_d;
                        wd_q        <= 8'd0;
                    end else if (if_req) begin
                        state_q    <= BUS_I;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= if_addr;
                        streak_q   <= 4'd0;
                        wd_q       <= 8'd0;
                    end
                end
                BUS_I, BUS_D: begin
                    // A real ack wins over a watchdog expiry on the same edge.
                    if (w_done) begin
                        state_q   <= RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        if (!mem_ack) begin
                            bus_err_q <= 1'b1;
                        end
                        if (state_q == BUS_I) begin
                            if_ready_q <= 1'b1;
                            if_rdata_q <= mem_ack ? mem_rdata : 32'd0;
                        end else begin
                            d_ready_q <= 1'b1;
                            if (!mem_we_q) begin
                                d_rdata_q <= mem_ack ? mem_rdata : 32'd0;
                            end
                        end
                    end else begin
                        wd_q <= wd_q + 8'd1;
                    end
                end
                RESP: begin
                    state_q    <= IDLE;
                    if_ready_q <= 1'b0;
                    d_ready_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ready  = if_ready_q;
    assign d_ready   = d_ready_q;
    assign bus_err   = bus_err_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_d   = d_req & ~d_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_mem_arb.sv
`default_nettype none
// ============================================================================
// Module : tb_pipe_mem_arb
// Brief  : Scoreboard bench: expected grants/responses queued, monitor compares.
// Rev    : 1.0
// ============================================================================
module tb_pipe_mem_arb;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = 32'd0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = 32'd0;
    logic [31:0] d_wdata = 32'd0;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_ack = 1'b0;
    logic        stall_if;
    logic        stall_d;
    logic        bus_err;

    always #5 clock = ~clock;

    pipe_mem_arb #(.FAIR(2), .MAXWAIT(15)) dut (
        .clock(clock), .resetn(resetn),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_if(stall_if), .stall_d(stall_d), .bus_err(bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          chk_wd;
    } grant_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } resp_t;

    grant_t gq[$];
    resp_t  rq[$];
    int     n_chk = 0;
    int     n_fail = 0;
    int     req_hi = 0;
    bit     ack_en = 1'b1;
    int     ack_lat = 1;
    int     force_req = 0;
    int     force_seen = 0;
    int     rsp_cnt = 0;
    logic   prev_req = 1'b0;
    grant_t mg;
    resp_t  mr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_image(input logic [31:0] a);
        if (a == 32'h100) return 32'h8C01_0004;
        return {~a[15:0], a[15:0]};
    endfunction

    // Memory responder: acks ack_lat cycles after a request is seen.
    always @(negedge clock) begin
        if (mem_ack) begin
            mem_ack = 1'b0;
        end else if (force_req != force_seen) begin
            force_seen = force_req;
            mem_ack    = 1'b1;
            mem_rdata  = 32'hDEAD_BEEF;
        end else if (mem_req && ack_en) begin
            rsp_cnt++;
            if (rsp_cnt >= ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_image(mem_addr);
                rsp_cnt   = 0;
            end
        end else begin
            rsp_cnt = 0;
        end
    end

    // Monitor: compares every grant and every ready pulse against the queues.
    always @(negedge clock) begin
        if (mem_req && !prev_req) begin
            if (gq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL grant_unexpected: got addr %h expected no grant", mem_addr);
            end else begin
                mg = gq.pop_front();
                check("grant_addr", mem_addr, mg.addr);
                check("grant_we", {31'd0, mem_we}, {31'd0, mg.we});
                if (mg.chk_wd) check("grant_wdata", mem_wdata, mg.wdata);
            end
        end
        prev_req = mem_req;
        if (mem_req) req_hi++;
        if (if_ready || d_ready) begin
            if (rq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL ready_unexpected: got if_ready %b d_ready %b expected none",
                         if_ready, d_ready);
            end else begin
                mr = rq.pop_front();
                check("resp_if_ready", {31'd0, if_ready}, {31'd0, ~mr.is_d});
                check("resp_d_ready", {31'd0, d_ready}, {31'd0, mr.is_d});
                check(mr.is_d ? "resp_d_rdata" : "resp_if_rdata",
                      mr.is_d ? d_rdata : if_rdata, mr.rdata);
            end
        end
    end

    task automatic push_g(input logic we, input logic [31:0] a, input logic [31:0] wd, input bit cw);
        grant_t g;
        g.we = we; g.addr = a; g.wdata = wd; g.chk_wd = cw;
        gq.push_back(g);
    endtask

    task automatic push_r(input bit is_d, input logic [31:0] rd);
        resp_t r;
        r.is_d = is_d; r.rdata = rd;
        rq.push_back(r);
    endtask

    task automatic do_fetch(input logic [31:0] a);
        bit seen = 1'b0;
        if_addr = a;
        if_req  = 1'b1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            seen = if_ready;
        end
        check("fetch_done", {31'd0, seen}, 32'd1);
        if_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
        bit seen = 1'b0;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clock);
            seen = d_ready;
        end
        check("data_done", {31'd0, seen}, 32'd1);
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int pulses;
        bit seen;

        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_ready", {30'd0, if_ready, d_ready}, 32'd0);
        check("rst_bus_err", {31'd0, bus_err}, 32'd0);
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        // Single fetch with one-cycle ack latency.
        push_g(1'b0, 32'h100, 32'd0, 1'b0);
        push_r(1'b0, 32'h8C01_0004);
        fork
            do_fetch(32'h100);
            begin
                #1;
                check("stall_if_wait", {31'd0, stall_if}, 32'd1);
                check("stall_d_idle", {31'd0, stall_d}, 32'd0);
            end
        join
        check("stall_if_done", {31'd0, stall_if}, 32'd0);
        @(negedge clock);

        // Simultaneous fetch and load: data wins first.
        push_g(1'b0, 32'h40, 32'd0, 1'b0);
        push_g(1'b0, 32'h200, 32'd0, 1'b0);
        push_r(1'b1, 32'hFFBF_0040);
        push_r(1'b0, 32'hFDFF_0200);
        fork
            do_fetch(32'h200);
            do_data(1'b0, 32'h40, 32'd0);
        join
        @(negedge clock);

        // Store with two-cycle ack: d_rdata keeps the earlier load value.
        ack_lat = 2;
        push_g(1'b1, 32'h40, 32'h1234, 1'b1);
        push_r(1'b1, 32'hFFBF_0040);
        do_data(1'b1, 32'h40, 32'h1234);
        ack_lat = 1;
        @(negedge clock);

        // Both held high: grant order D,D,I,D,D,I.
        for (int i = 0; i < 2; i++) begin
            push_g(1'b0, 32'h40, 32'd0, 1'b0);
            push_g(1'b0, 32'h40, 32'd0, 1'b0);
            push_g(1'b0, 32'h200, 32'd0, 1'b0);
            push_r(1'b1, 32'hFFBF_0040);
            push_r(1'b1, 32'hFFBF_0040);
            push_r(1'b0, 32'hFDFF_0200);
        end
        if_addr = 32'h200;
        d_we    = 1'b0;
        d_addr  = 32'h40;
        if_req  = 1'b1;
        d_req   = 1'b1;
        pulses  = 0;
        for (int k = 0; k < 200 && pulses < 2; k++) begin
            @(negedge clock);
            if (if_ready) pulses++;
        end
        check("fair_if_pulses", pulses, 32'd2);
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clock);

        // Watchdog: load never acked.
        ack_en = 1'b0;
        base   = req_hi;
        push_g(1'b0, 32'h80, 32'd0, 1'b0);
        push_r(1'b1, 32'd0);
        do_data(1'b0, 32'h80, 32'h0);
        check("wd_req_cycles", req_hi - base, 32'd15);
        check("wd_bus_err", {31'd0, bus_err}, 32'd1);
        ack_en = 1'b1;
        @(negedge clock);
        push_g(1'b0, 32'h100, 32'd0, 1'b0);
        push_r(1'b0, 32'h8C01_0004);
        do_fetch(32'h100);
        check("wd_bus_err_sticky", {31'd0, bus_err}, 32'd1);
        @(negedge clock);

        // Reset while a fetch is on the bus.
        ack_en = 1'b0;
        push_g(1'b0, 32'h300, 32'd0, 1'b0);
        if_addr = 32'h300;
        if_req  = 1'b1;
        seen    = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            seen = mem_req;
        end
        check("rst_bus_granted", {31'd0, seen}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_async_bus_err", {31'd0, bus_err}, 32'd0);
        check("rst_async_if_rdata", if_rdata, 32'd0);
        if_req    = 1'b0;
        force_req = force_req + 1;
        repeat (2) @(negedge clock);
        resetn    = 1'b1;
        force_req = force_req + 1;
        repeat (4) @(negedge clock);
        check("rst_late_ack_req", {31'd0, mem_req}, 32'd0);
        check("rst_late_ack_rdata", if_rdata, 32'd0);
        ack_en = 1'b1;

        // First arbitration after reset: data first again.
        push_g(1'b0, 32'h40, 32'd0, 1'b0);
        push_g(1'b0, 32'h200, 32'd0, 1'b0);
        push_r(1'b1, 32'hFFBF_0040);
        push_r(1'b0, 32'hFDFF_0200);
        fork
            do_fetch(32'h200);
            do_data(1'b0, 32'h40, 32'd0);
        join
        repeat (3) @(negedge clock);

        check("grant_queue_empty", gq.size(), 32'd0);
        check("resp_queue_empty", rq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
